ece178_led_out_pio: RTL and testbench

//   Avalon-MM slave output PIO with an optional hardware blink engine. Nios II

---
 rtl/ece178_led_out_pio.sv | 110 +++++++++++
 tb/tb_ece178_led_out_pio.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ece178_led_out_pio.sv
// Avalon-MM output PIO driving board LEDs, with a per-bit hardware blink engine.
// Define LED_PIO_BITMODIFY_EN to add the OUTSET/OUTCLR bit set/clear registers.
module ece178_led_out_pio #(
  parameter int                    DATA_WIDTH  = 18,
  parameter int                    CNT_WIDTH   = 26,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port
);

  localparam logic [2:0] A_DATA   = 3'd0;
  localparam logic [2:0] A_MASK   = 3'd1;
  localparam logic [2:0] A_PERIOD = 3'd2;
  localparam logic [2:0] A_OUT    = 3'd3;
`ifdef LED_PIO_BITMODIFY_EN
  localparam logic [2:0] A_OUTSET = 3'd4;
  localparam logic [2:0] A_OUTCLR = 3'd5;
`endif

  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] mask_q, mask_d;
  logic [CNT_WIDTH-1:0]  period_q, period_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  phase_q, phase_d;
  logic [31:0]           readdata_q, readdata_d;

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [CNT_WIDTH-1:0]  wr_period;

  assign wr_en     = chipselect & ~write_n;
  assign wr_data   = writedata[DATA_WIDTH-1:0];
  assign wr_period = writedata[CNT_WIDTH-1:0];

  assign out_port = data_q ^ (mask_q & {DATA_WIDTH{phase_q}});
  assign readdata = readdata_q;

  always_comb begin
    data_d   = data_q;
    mask_d   = mask_q;
    period_d = period_q;
    if (wr_en) begin
      case (address)
        A_DATA:   data_d   = wr_data;
        A_MASK:   mask_d   = wr_data;
        A_PERIOD: period_d = wr_period;
`ifdef LED_PIO_BITMODIFY_EN
        A_OUTSET: data_d   = data_q | wr_data;
        A_OUTCLR: data_d   = data_q & ~wr_data;
`endif
        default: ;
      endcase
    end
  end

  // A PERIOD write restarts the blink cycle from phase 0, overriding any wrap.
  always_comb begin
    count_d = count_q;
    phase_d = phase_q;
    if (wr_en && address == A_PERIOD) begin
      count_d = '0;
      phase_d = 1'b0;
    end else if (period_q == '0) begin
      count_d = '0;
      phase_d = 1'b0;
    end else if (count_q >= period_q - CNT_WIDTH'(1)) begin
      count_d = '0;
      phase_d = ~phase_q;
    end else begin
      count_d = count_q + CNT_WIDTH'(1);
    end
  end

  always_comb begin
    readdata_d = '0;
    case (address)
      A_DATA:   readdata_d = 32'(data_q);
      A_MASK:   readdata_d = 32'(mask_q);
      A_PERIOD: readdata_d = 32'(period_q);
      A_OUT:    readdata_d = 32'(out_port);
      default:  readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_q     <= RESET_VALUE;
      mask_q     <= '0;
      period_q   <= '0;
      count_q    <= '0;
      phase_q    <= 1'b0;
      readdata_q <= '0;
    end else begin
      data_q     <= data_d;
      mask_q     <= mask_d;
      period_q   <= period_d;
      count_q    <= count_d;
      phase_q    <= phase_d;
      readdata_q <= readdata_d;
    end
  end

endmodule

// File: tb/tb_ece178_led_out_pio.sv
// Scoreboard bench for ece178_led_out_pio: stimulus queues expected readdata /
// out_port values, a negedge monitor pops and compares one cycle later.
module tb_ece178_led_out_pio;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [17:0] out_port;

  ece178_led_out_pio dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_out;
    logic [31:0] exp;
    string       name;
  } item_t;

  item_t q[$];
  logic  req   = 1'b0;
  logic  vld_q = 1'b0;
  int    n_vec = 0;
  int    n_err = 0;

  always @(posedge clk) vld_q <= req;

  // Monitor: the output belonging to a request is visible after the edge it was sampled on.
  always @(negedge clk) begin
    if (vld_q) begin
      item_t it;
      logic [31:0] act;
      n_vec++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL scoreboard_empty: output presented with no expected value");
      end else begin
        it  = q.pop_front();
        act = it.is_out ? 32'(out_port) : readdata;
        if (act !== it.exp) begin
          n_err++;
          $display("FAIL %s: got 0x%08h expected 0x%08h", it.name, act, it.exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    req = 1'b0;
  endtask

  task automatic expect_val(input bit is_out, input logic [31:0] e, input string n);
    item_t it;
    it.is_out = is_out;
    it.exp    = e;
    it.name   = n;
    q.push_back(it);
    req = 1'b1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd_chk(input logic [2:0] a, input logic [31:0] e, input string n);
    address = a;
    expect_val(1'b0, e, n);
    tick();
  endtask

  task automatic out_chk(input logic [31:0] e, input string n);
    expect_val(1'b1, e, n);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] bm_exp;
    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0;

    // Reset state
    tick();
    out_chk(32'h0, "rst_out");
    rd_chk(3'd0, 32'h0, "rst_rd_in_reset");
    reset_n = 1'b1;
    rd_chk(3'd0, 32'h0, "rst_data");
    rd_chk(3'd1, 32'h0, "rst_mask");
    rd_chk(3'd2, 32'h0, "rst_period");
    rd_chk(3'd3, 32'h0, "rst_outreg");

    // Data write and readback
    wr(3'd0, 32'h0003A5A5);
    out_chk(32'h0003A5A5, "data_out");
    rd_chk(3'd0, 32'h0003A5A5, "data_rd");
    rd_chk(3'd3, 32'h0003A5A5, "outreg_rd");

    // Read during write of the same register returns the old value
    chipselect = 1'b1; write_n = 1'b0; address = 3'd0; writedata = 32'h00011111;
    expect_val(1'b0, 32'h0003A5A5, "rd_during_wr_old");
    tick();
    chipselect = 1'b0; write_n = 1'b1;
    rd_chk(3'd0, 32'h00011111, "rd_after_wr_new");

    // Upper writedata bits dropped
    wr(3'd0, 32'hFFFFFFFF);
    out_chk(32'h0003FFFF, "trunc_out");
    rd_chk(3'd0, 32'h0003FFFF, "trunc_rd");

    // Unused addresses: read 0, writes ignored
    wr(3'd6, 32'h12345678);
    wr(3'd7, 32'h0);
    rd_chk(3'd6, 32'h0, "addr6_rd");
    rd_chk(3'd7, 32'h0, "addr7_rd");
    rd_chk(3'd0, 32'h0003FFFF, "data_after_unused_wr");
    // Write without chipselect is ignored
    chipselect = 1'b0; write_n = 1'b0; address = 3'd0; writedata = 32'h0;
    tick();
    write_n = 1'b1;
    rd_chk(3'd0, 32'h0003FFFF, "no_cs_no_write");

    // Blink, PERIOD=4: phase after k-th edge following the write = (k/4)%2
    wr(3'd0, 32'h100);
    wr(3'd1, 32'h3);
    rd_chk(3'd1, 32'h3, "mask_rd");
    wr(3'd2, 32'd4);
    for (int k = 1; k <= 10; k++)
      out_chk(((k / 4) % 2) ? 32'h103 : 32'h100, $sformatf("blink4_k%0d", k));
    rd_chk(3'd2, 32'd4, "period_rd");
    wr(3'd2, 32'd0);
    for (int k = 1; k <= 3; k++)
      out_chk(32'h100, $sformatf("blink_off_k%0d", k));

    // PERIOD=10, let count reach 7, then lower to 3
    wr(3'd2, 32'd10);
    for (int k = 1; k <= 7; k++) tick();
    wr(3'd2, 32'd3);
    for (int k = 1; k <= 9; k++)
      out_chk(((k / 3) % 2) ? 32'h103 : 32'h100, $sformatf("period3_k%0d", k));
    // New mask applied with the running phase (write is edge k=10)
    wr(3'd1, 32'hC);
    for (int k = 11; k <= 13; k++)
      out_chk(((k / 3) % 2) ? 32'h10C : 32'h100, $sformatf("mask_chg_k%0d", k));

    // Reset mid-operation discards the pending write
    chipselect = 1'b1; write_n = 1'b0; address = 3'd0; writedata = 32'h2AAAA;
    reset_n = 1'b0;
    expect_val(1'b1, 32'h0, "midrst_out");
    tick();
    chipselect = 1'b0; write_n = 1'b1; reset_n = 1'b1;
    rd_chk(3'd0, 32'h0, "midrst_data");
    rd_chk(3'd1, 32'h0, "midrst_mask");
    rd_chk(3'd2, 32'h0, "midrst_period");

    // Bit set/clear
`ifdef LED_PIO_BITMODIFY_EN
    bm_exp = 32'h00C3;
`else
    bm_exp = 32'h00F0;
`endif
    wr(3'd0, 32'h00F0);
    wr(3'd4, 32'h0003);
    wr(3'd5, 32'h0030);
    rd_chk(3'd0, bm_exp, "bitmodify_data");
    rd_chk(3'd4, 32'h0, "outset_rd");
    rd_chk(3'd5, 32'h0, "outclr_rd");
    out_chk(bm_exp, "bitmodify_out");

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard_leftover: %0d pending expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
